// File: rtl/ising_dac_channel_bank.sv
// Multi-channel DAC feeder: per-channel FWFT FIFOs released together once every
// enabled channel has reached its start level; empty-FIFO reads count as underflow.
module ising_dac_channel_bank #(
    parameter int NUM_CH      = 9,
    parameter int DATA_W      = 256,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              gpio_in,
    output logic [31:0]              gpio_out_bus,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    input  logic [NUM_CH-1:0]        m_axis_tready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              sticky_q, sticky_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              arm_s_q, arm_s_d, arm_p_q, arm_p_d;
    logic              stop_s_q, stop_s_d, stop_p_q, stop_p_d;

    logic [PW-1:0]     wr_ptr_q [NUM_CH];
    logic [PW-1:0]     wr_ptr_d [NUM_CH];
    logic [PW-1:0]     rd_ptr_q [NUM_CH];
    logic [PW-1:0]     rd_ptr_d [NUM_CH];
    logic [DATA_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [NUM_CH][FIFO_DEPTH];

    logic [PW-1:0]     fill [NUM_CH];
    logic [DATA_W-1:0] head [NUM_CH];
    logic [NUM_CH-1:0] empty, full, push, pop, uf;
    logic [NUM_CH-1:0] gpio_mask;
    logic              primed, arm_edge, stop_edge;
    logic [31:0]       gpio_unused;

    // Upper control bits beyond the mask field carry no function.
    assign gpio_unused = gpio_in;
    assign gpio_mask   = gpio_in[NUM_CH+1:2];
    assign arm_edge    = arm_s_q & ~arm_p_q;
    assign stop_edge   = stop_s_q & ~stop_p_q;

    always_comb begin
        primed        = |mask_q;
        empty         = '0;
        full          = '0;
        push          = '0;
        pop           = '0;
        uf            = '0;
        s_axis_tready = '0;
        m_axis_tvalid = '0;
        m_axis_tdata  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            fill[k]  = wr_ptr_q[k] - rd_ptr_q[k];
            head[k]  = mem_q[k][rd_ptr_q[k][AW-1:0]];
            empty[k] = (fill[k] == '0);
            full[k]  = (fill[k] == PW'(FIFO_DEPTH));
            if (mask_q[k] && (fill[k] < PW'(START_LEVEL))) begin
                primed = 1'b0;
            end
            s_axis_tready[k] = ~full[k] && (state_q != ST_FLUSH);
            push[k]          = s_axis_tvalid[k] & s_axis_tready[k];
            if (state_q == ST_RUNNING && mask_q[k]) begin
                m_axis_tvalid[k] = 1'b1;
                pop[k]           = m_axis_tready[k] & ~empty[k];
                uf[k]            = m_axis_tready[k] & empty[k];
                if (!empty[k]) begin
                    m_axis_tdata[k*DATA_W +: DATA_W] = head[k];
                end
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (state_q == ST_FLUSH) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
            end else begin
                wr_ptr_d[k] = wr_ptr_q[k] + PW'(push[k]);
                rd_ptr_d[k] = rd_ptr_q[k] + PW'(pop[k]);
            end
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k][AW-1:0]] = s_axis_tdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        arm_s_d  = gpio_in[0];
        arm_p_d  = arm_s_q;
        stop_s_d = gpio_in[1];
        stop_p_d = stop_s_q;
        if (stop_edge && state_q != ST_FLUSH) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_edge && (|gpio_mask)) begin
                        state_d  = ST_ARMED;
                        mask_d   = gpio_mask;
                        sticky_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
                ST_ARMED:   if (primed) state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_RUNNING;
                default:    state_d = ST_IDLE;
            endcase
        end
        // Underflow only occurs in RUNNING, so it never collides with the arm clear.
        if (|uf) begin
            sticky_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            arm_s_q  <= 1'b0;
            arm_p_q  <= 1'b0;
            stop_s_q <= 1'b0;
            stop_p_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            arm_s_q  <= arm_s_d;
            arm_p_q  <= arm_p_d;
            stop_s_q <= stop_s_d;
            stop_p_q <= stop_p_d;
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
        end
    end

    // Sample storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign gpio_out_bus = {cnt_q, 12'd0, primed, sticky_q, state_q};

endmodule

// File: tb/tb_ising_dac_channel_bank.sv
// Directed bench for ising_dac_channel_bank: stimulus pushes expected DAC words
// into per-channel queues, a negedge monitor pops and compares every output beat.
module tb_ising_dac_channel_bank;
    localparam int NUM_CH      = 9;
    localparam int DATA_W      = 256;
    localparam int FIFO_DEPTH  = 16;
    localparam int START_LEVEL = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [31:0]              gpio_in = '0;
    logic [31:0]              gpio_out;
    logic [NUM_CH*DATA_W-1:0] s_tdata = '0;
    logic [NUM_CH-1:0]        s_tvalid = '0;
    logic [NUM_CH-1:0]        s_tready;
    logic [NUM_CH*DATA_W-1:0] m_tdata;
    logic [NUM_CH-1:0]        m_tvalid;
    logic [NUM_CH-1:0]        m_tready = '0;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    logic [15:0]       exp_cnt = '0;
    bit                mon_uf;

    ising_dac_channel_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .START_LEVEL(START_LEVEL)
    ) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out_bus(gpio_out),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
    );

    always #2 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word(input int ch, input int seq);
        return {8{32'(ch * 1000 + seq) ^ 32'h5A5A_0000}};
    endfunction

    // Monitor: every accepted beat pops the channel queue; an empty queue means a zero word.
    always @(negedge clk) begin
        if (!rst) begin
            mon_uf = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (m_tvalid[k] && m_tready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        mon_uf = 1'b1;
                        check("underflow_word", m_tdata[k*DATA_W +: DATA_W], '0);
                    end else begin
                        check("dout", m_tdata[k*DATA_W +: DATA_W], exp_q[k].pop_front());
                    end
                end else if (!m_tvalid[k]) begin
                    check("idle_zero", m_tdata[k*DATA_W +: DATA_W], '0);
                end
            end
            if (mon_uf && exp_cnt != 16'hFFFF) exp_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    endtask

    task automatic wait_state(input logic [1:0] st, input string name);
        int n = 0;
        while (gpio_out[1:0] !== st && n < 12) begin
            tick();
            n++;
        end
        check(name, DATA_W'(gpio_out[1:0]), DATA_W'(st));
    endtask

    task automatic arm(input logic [NUM_CH-1:0] mask);
        gpio_in = (32'(mask) << 2) | 32'h1;
        wait_state(2'd1, "arm_to_armed");
        gpio_in[0] = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic stop();
        gpio_in[1] = 1'b1;
        wait_state(2'd3, "stop_to_flush");
        clear_model();
        tick();
        check("flush_one_cycle", DATA_W'(gpio_out[1:0]), DATA_W'(2'd0));
        gpio_in[1] = 1'b0;
    endtask

    task automatic send_all(input logic [NUM_CH-1:0] mask, input int seq);
        for (int k = 0; k < NUM_CH; k++) begin
            s_tdata[k*DATA_W +: DATA_W] = word(k, seq);
            if (mask[k]) exp_q[k].push_back(word(k, seq));
        end
        s_tvalid = mask;
        check("send_all_ready", DATA_W'(s_tready & mask), DATA_W'(mask));
        tick();
        s_tvalid = '0;
    endtask

    task automatic send_word(input int ch, input logic [DATA_W-1:0] w);
        int n = 0;
        s_tdata[ch*DATA_W +: DATA_W] = w;
        s_tvalid[ch] = 1'b1;
        while (!s_tready[ch] && n < 50) begin
            tick();
            n++;
        end
        check("send_word_ready", DATA_W'(s_tready[ch]), DATA_W'(1'b1));
        if (s_tready[ch]) exp_q[ch].push_back(w);
        tick();
        s_tvalid[ch] = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick(); tick();
        check("rst_tvalid", DATA_W'(m_tvalid), '0);
        check("rst_tdata_ch0", m_tdata[DATA_W-1:0], '0);
        check("rst_state", DATA_W'(gpio_out[1:0]), '0);
        rst = 1'b0;
        tick();
        check("rst_status", DATA_W'({gpio_out[31:16], gpio_out[2]}), '0);
        check("rst_s_tready", DATA_W'(s_tready), DATA_W'(9'h1FF));

        // Arm and stop rising together: stop wins, then back to IDLE
        gpio_in = (32'h1FF << 2) | 32'h3;
        wait_state(2'd3, "both_edges_flush");
        tick();
        check("both_edges_idle", DATA_W'(gpio_out[1:0]), '0);
        gpio_in = '0;
        tick(); tick(); tick();
        check("both_edges_stay_idle", DATA_W'(gpio_out[1:0]), '0);

        // Synchronized start of all nine channels
        arm(9'h1FF);
        for (int i = 0; i < 3; i++) send_all(9'h1FF, i);
        check("not_primed_3", DATA_W'(gpio_out[3:0]), DATA_W'(4'b0001));
        send_all(9'h1FF, 3);
        check("primed_4", DATA_W'(gpio_out[3:0]), DATA_W'(4'b1001));
        tick();
        check("running_next_cycle", DATA_W'(gpio_out[1:0]), DATA_W'(2'd2));
        check("all_valid", DATA_W'(m_tvalid), DATA_W'(9'h1FF));
        for (int k = 0; k < NUM_CH; k++) check("word0_present", m_tdata[k*DATA_W +: DATA_W], word(k, 0));
        m_tready = '1;
        for (int i = 0; i < 4; i++) tick();
        m_tready = '0;
        check("no_underflow_a", DATA_W'(gpio_out[2]), '0);
        stop();

        // Full FIFO holds the 17th word until the first pop
        for (int i = 0; i < FIFO_DEPTH; i++) send_word(0, word(0, 100 + i));
        check("full_not_ready", DATA_W'(s_tready[0]), '0);
        check("others_ready", DATA_W'(s_tready[8:1]), DATA_W'(8'hFF));
        arm(9'h001);
        wait_state(2'd2, "full_running");
        check("full_still_held", DATA_W'(s_tready[0]), '0);
        m_tready[0] = 1'b1;
        send_word(0, word(0, 116));
        for (int i = 0; i < 20; i++) tick();
        m_tready = '0;
        check("drain_uf_count", DATA_W'(gpio_out[31:16]), DATA_W'(16'd5));
        check("drain_uf_model", DATA_W'(gpio_out[31:16]), DATA_W'(exp_cnt));
        check("drain_sticky", DATA_W'(gpio_out[2]), DATA_W'(1'b1));
        stop();
        check("sticky_kept_idle", DATA_W'(gpio_out[2]), DATA_W'(1'b1));

        // Two channels, then continuous underflow
        arm(9'h003);
        check("arm_clears_status", DATA_W'({gpio_out[31:16], gpio_out[2]}), '0);
        for (int i = 0; i < 4; i++) send_all(9'h003, 200 + i);
        wait_state(2'd2, "two_ch_running");
        check("two_ch_valid", DATA_W'(m_tvalid), DATA_W'(9'h003));
        m_tready = '1;
        for (int i = 0; i < 4; i++) tick();
        check("no_uf_yet", DATA_W'(gpio_out[31:16]), '0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("uf_count_step", DATA_W'(gpio_out[31:16]), DATA_W'(i));
        end
        check("uf_sticky", DATA_W'(gpio_out[2]), DATA_W'(1'b1));

        // Saturation, retention through FLUSH, clear on next arm
        for (int i = 0; i < 70000; i++) tick();
        check("uf_saturated", DATA_W'(gpio_out[31:16]), DATA_W'(16'hFFFF));
        check("uf_sat_model", DATA_W'(gpio_out[31:16]), DATA_W'(exp_cnt));
        m_tready = '0;
        stop();
        check("sat_kept_idle", DATA_W'(gpio_out[31:16]), DATA_W'(16'hFFFF));
        arm(9'h001);
        check("sat_cleared", DATA_W'({gpio_out[31:16], gpio_out[2]}), '0);
        stop();

        // Reset in the middle of RUNNING with buffered data
        arm(9'h1FF);
        for (int i = 0; i < 4; i++) send_all(9'h1FF, 300 + i);
        wait_state(2'd2, "pre_rst_running");
        check("pre_rst_valid", DATA_W'(m_tvalid), DATA_W'(9'h1FF));
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", DATA_W'(m_tvalid), '0);
        check("mid_rst_tdata_ch4", m_tdata[4*DATA_W +: DATA_W], '0);
        check("mid_rst_state", DATA_W'(gpio_out[1:0]), '0);
        clear_model();
        exp_cnt = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", DATA_W'(s_tready), DATA_W'(9'h1FF));
        arm(9'h001);
        tick(); tick(); tick();
        check("post_rst_fifo_empty", DATA_W'(gpio_out[3:0]), DATA_W'(4'b0001));
        stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
